mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master and the data (MEM-stage) master of the MIPS core.
- The data master supplies byte strobes already decoded by the store byte-lane logic: 4'b0000 for loads and exceptions, 4'b1111 for sw.
- Allows one outstanding transaction at a time.
- Data master has priority; a streak counter prevents fetch starvation.

Parameters:
- STREAK_MAX, 4: maximum consecutive data grants while inst_req is pending before inst is forced through. Legal range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch request; held until inst_addr_ok.
- inst_addr  in  AW  fetch address.
- inst_size  in  2  transfer size, always 2'b10 for fetch.
- inst_addr_ok  out  1  fetch address accepted.
- inst_data_ok  out  1  fetch data returned.
- inst_rdata  out  DW  fetch read data.
- data_req  in  1  data request; held until data_addr_ok.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  2'b00 byte, 2'b01 half, 2'b10 word.
- data_addr  in  AW  data address.
- data_wdata  in  DW  write data.
- data_wstrb  in  4  byte strobes.
- data_addr_ok  out  1  data address accepted.
- data_data_ok  out  1  data response.
- data_rdata  out  DW  data read data.
- bus_req  out  1  request to slave.
- bus_wr  out  1  write flag to slave.
- bus_size  out  2  size to slave.
- bus_addr  out  AW  address to slave.
- bus_wdata  out  DW  write data to slave.
- bus_wstrb  out  4  byte strobes to slave.
- bus_addr_ok  in  1  slave accepted address.
- bus_data_ok  in  1  slave response.
- bus_rdata  in  DW  slave read data.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, owner=INST, streak=0.
  - All outputs 0, including bus_* fields, which are zeroed whenever bus_req=0.
- States: IDLE, ADDR, RESP. Exactly one owner register selects the mux.
- IDLE:
  - Grant rules:
    - data_req and not (inst_req and streak==STREAK_MAX) -> owner=DATA.
    - Else inst_req -> owner=INST.
    - Neither -> stay in IDLE.
  - Any grant moves to ADDR next cycle, so grant latency is 1 cycle.
  - Streak update at grant:
    - DATA grant with inst_req=1 -> streak+1, saturating at STREAK_MAX.
    - INST grant -> streak=0.
    - DATA grant with inst_req=0 -> streak=0.
- ADDR:
  - bus_req=1. bus_wr/size/addr/wdata/wstrb are a combinational mux of the owner's inputs. For an INST owner, bus_wr=0, bus_wstrb=0 and bus_wdata=0.
  - On bus_addr_ok=1: pulse owner's *_addr_ok in the same cycle and go to RESP. The other master's addr_ok stays 0.
  - bus_data_ok in ADDR is a protocol violation and is ignored.
  - Owner's req dropping before addr_ok is illegal; the arbiter holds the ADDR state regardless.
- RESP:
  - bus_req=0.
  - On bus_data_ok=1: owner's *_data_ok=1 and *_rdata=bus_rdata in the same cycle, then go to IDLE.
  - Non-owner's data_ok=0 and its rdata=0.
- Minimum request-to-request spacing is 3 cycles: IDLE, ADDR, RESP.
- Data write with data_wstrb=0 (store suppressed by an address exception) is still issued as a transaction. The slave performs no byte write; the arbiter does not filter it.
- Simultaneous inst_req and data_req in IDLE are resolved only by the grant rules above; there is no same-cycle dual grant.

Decomposition:
- Shared package/header (defines.vh): state encodings ST_IDLE=2'd0, ST_ADDR=2'd1, ST_RESP=2'd2; owner encodings OWN_INST=1'b0, OWN_DATA=1'b1; size codes SIZE_B/H/W.
- Sub-module: bus_req_mux, a combinational 2:1 mux of the request fields keyed by owner.
- FSM and streak counter live in the top-level module.

Test Plan:
- Single fetch: inst_req=1, addr=0xBFC00000. Expect bus_req=1 one cycle later with bus_addr=0xBFC00000, bus_wr=0. Then bus_addr_ok=1 -> inst_addr_ok=1. Then bus_data_ok=1 with bus_rdata=0x3C1D0000 -> inst_data_ok=1, inst_rdata=0x3C1D0000, data_data_ok=0.
- Collision: inst_req=1 and data_req=1 (sb, addr=0x80000003, wstrb=4'b1000) in the same cycle. Expect the data transaction first (bus_wstrb=4'b1000, bus_size=2'b00), then the fetch.
- Starvation guard: inst_req held, data_req held continuously, STREAK_MAX=4. Expect exactly 4 data grants, then 1 inst grant, then streak resets to 0.
- Reset mid-transaction: assert resetn=0 while in RESP. Expect outputs 0 immediately without waiting for a clock edge. A later bus_data_ok is not forwarded; first grant after reset behaves as from IDLE.
- Slave stalls: bus_addr_ok delayed 5 cycles. Expect bus_req and bus_addr held stable throughout, and addr_ok pulsed for exactly one cycle. A spurious bus_data_ok in ADDR produces no data_ok.
- Suppressed store: data_wr=1, data_wstrb=4'b0000. Expect the transaction issued with bus_wstrb=0, and data_data_ok returned normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and helpers for the fetch/data memory-port arbiter.
// The state, owner and size codes are common to the top and the request mux.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int STREAK_W = 4;

  function automatic logic size_is_legal(input logic [1:0] size);
    return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
  endfunction

  // A data win only counts against fetch when fetch was actually waiting.
  function automatic logic [STREAK_W-1:0] streak_after_data_grant(
    input logic                inst_waiting,
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] lim
  );
    if (!inst_waiting) return '0;
    if (cur >= lim) return lim;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like request/response channels: a full read/write channel used for
// the data master and the memory side, and a read-only channel for fetch.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata, wstrb,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, wstrb,
    output addr_ok, data_ok, rdata
  );
endinterface

interface mem_bus_arbiter_fetch_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (
    output req, size, addr,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, size, addr,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_bus_req_mux.sv
// Combinational 2:1 selection of request fields by the current owner.
// Fetch never writes, so its write-side fields are forced to zero.
module mem_bus_arbiter_bus_req_mux
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  owner_e        owner,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic [3:0]    data_wstrb,
  output logic          wr,
  output logic [1:0]    size,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic [3:0]    wstrb
);

  always_comb begin
    wr    = 1'b0;
    size  = inst_size;
    addr  = inst_addr;
    wdata = '0;
    wstrb = '0;
    if (owner == OWN_DATA) begin
      wr    = data_wr;
      size  = data_size;
      addr  = data_addr;
      wdata = data_wdata;
      wstrb = data_wstrb;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between the fetch and data masters.
// Data has priority; a streak counter forces fetch through after STREAK_MAX data wins.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  mem_bus_arbiter_fetch_if.slave   inst,
  mem_bus_arbiter_if.slave         data,
  mem_bus_arbiter_if.master        bus
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

  state_e              state_q,  state_d;
  owner_e              owner_q,  owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic          data_win;
  logic          mux_wr;
  logic [1:0]    mux_size;
  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;
  logic [3:0]    mux_wstrb;

  assign data_win = data.req && !(inst.req && (streak_q == STREAK_LIM));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_INST;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Grant is decided only from IDLE; owner and streak are frozen until the response returns.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (data_win) begin
          owner_d  = OWN_DATA;
          state_d  = ST_ADDR;
          streak_d = streak_after_data_grant(inst.req, streak_q, STREAK_LIM);
        end else if (inst.req) begin
          owner_d  = OWN_INST;
          state_d  = ST_ADDR;
          streak_d = '0;
        end
      end
      ST_ADDR: begin
        if (bus.addr_ok) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_bus_arbiter_bus_req_mux #(
    .AW (AW),
    .DW (DW)
  ) u_bus_req_mux (
    .owner      (owner_q),
    .inst_size  (inst.size),
    .inst_addr  (inst.addr),
    .data_wr    (data.wr),
    .data_size  (data.size),
    .data_addr  (data.addr),
    .data_wdata (data.wdata),
    .data_wstrb (data.wstrb),
    .wr         (mux_wr),
    .size       (mux_size),
    .addr       (mux_addr),
    .wdata      (mux_wdata),
    .wstrb      (mux_wstrb)
  );

  // Everything is derived from state so an asynchronous reset clears all outputs at once.
  always_comb begin
    bus.req       = 1'b0;
    bus.wr        = 1'b0;
    bus.size      = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.wstrb     = '0;
    inst.addr_ok  = 1'b0;
    inst.data_ok  = 1'b0;
    inst.rdata    = '0;
    data.addr_ok  = 1'b0;
    data.data_ok  = 1'b0;
    data.rdata    = '0;
    case (state_q)
      ST_ADDR: begin
        bus.req   = 1'b1;
        bus.wr    = mux_wr;
        bus.size  = mux_size;
        bus.addr  = mux_addr;
        bus.wdata = mux_wdata;
        bus.wstrb = mux_wstrb;
        if (owner_q == OWN_DATA) data.addr_ok = bus.addr_ok;
        else                     inst.addr_ok = bus.addr_ok;
      end
      ST_RESP: begin
        if (bus.data_ok) begin
          if (owner_q == OWN_DATA) begin
            data.data_ok = 1'b1;
            data.rdata   = bus.rdata;
          end else begin
            inst.data_ok = 1'b1;
            inst.rdata   = bus.rdata;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
